// File: rtl/l1_data_cache_pkg.sv
// Shared constants and types for the direct-mapped L1 data cache.
// Line size and set count are fixed here; the tag width is derived.
package cache_types;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 32 - S_OFFSET - S_INDEX;

    typedef logic [255:0] line_t;

    typedef enum logic [1:0] {
        CHECK,
        WRITEBACK,
        FILL
    } cache_state_t;

endpackage

// File: rtl/l1_data_cache_array.sv
// Per-set storage: tag, valid, dirty and one 256-bit line with byte write enables.
// Reads are combinational; only valid/dirty are cleared by reset.
module cache_array
    import cache_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] index,
    input  logic [31:0]        byte_we,
    input  line_t              line_in,
    input  logic               fill,
    input  logic [S_TAG-1:0]   tag_in,
    input  logic               set_dirty,
    output logic [S_TAG-1:0]   tag_out,
    output logic               valid_out,
    output logic               dirty_out,
    output line_t              line_out
);

    localparam int SETS = 1 << S_INDEX;

    logic [SETS-1:0]  valid;
    logic [SETS-1:0]  dirty;
    logic [S_TAG-1:0] tags  [SETS];
    line_t            lines [SETS];

    // A fill always leaves the line clean, even if a store hit is pending elsewhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (set_dirty) begin
            dirty[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[index] <= tag_in;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 32; b++) begin
            if (byte_we[b]) begin
                lines[index][8*b +: 8] <= line_in[8*b +: 8];
            end
        end
    end

    assign tag_out   = tags[index];
    assign valid_out = valid[index];
    assign dirty_out = dirty[index];
    assign line_out  = lines[index];

endmodule

// File: rtl/l1_data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with zero-wait hits.
// Handshake: the CPU holds its request until data_resp=1; the cache holds pmem_read/pmem_write until pmem_resp=1.
module l1_data_cache
    import cache_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  data_addr,
    input  logic [31:0]  data_wdata,
    input  logic [3:0]   data_mbe,
    input  logic         data_read,
    input  logic         data_write,
    output logic [31:0]  data_rdata,
    output logic         data_resp,
    output logic [31:0]  pmem_address,
    input  line_t        pmem_rdata,
    output line_t        pmem_wdata,
    output logic         pmem_read,
    output logic         pmem_write,
    input  logic         pmem_resp,
    output cache_state_t fsm_state
);

    cache_state_t state, next_state;

    logic [S_TAG-1:0]   req_tag;
    logic [S_INDEX-1:0] index;
    logic [2:0]         word;
    logic               request;
    logic               hit;
    logic               unused_addr_bits;

    logic [S_TAG-1:0] tag_out;
    logic             valid_out;
    logic             dirty_out;
    line_t            line_out;
    line_t            line_in;
    logic [31:0]      byte_we;
    logic             fill;
    logic             set_dirty;

    assign req_tag          = data_addr[31:S_OFFSET+S_INDEX];
    assign index            = data_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign word             = data_addr[S_OFFSET-1:2];
    assign unused_addr_bits = ^data_addr[1:0];
    assign request          = data_read | data_write;
    assign hit              = valid_out && (tag_out == req_tag);
    assign data_rdata       = line_out[{word, 5'b00000} +: 32];
    assign fsm_state        = state;

    cache_array u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .byte_we   (byte_we),
        .line_in   (line_in),
        .fill      (fill),
        .tag_in    (req_tag),
        .set_dirty (set_dirty),
        .tag_out   (tag_out),
        .valid_out (valid_out),
        .dirty_out (dirty_out),
        .line_out  (line_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CHECK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        data_resp    = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {req_tag, index, {S_OFFSET{1'b0}}};
        pmem_wdata   = line_out;
        byte_we      = '0;
        line_in      = {8{data_wdata}};
        fill         = 1'b0;
        set_dirty    = 1'b0;
        case (state)
            CHECK: begin
                if (request) begin
                    if (hit) begin
                        data_resp = 1'b1;
                        // A read+write collision is serviced as a write.
                        if (data_write) begin
                            byte_we   = 32'(data_mbe) << {word, 2'b00};
                            set_dirty = |data_mbe;
                        end
                    end else if (valid_out && dirty_out) begin
                        next_state = WRITEBACK;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_out, index, {S_OFFSET{1'b0}}};
                if (pmem_resp) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill       = 1'b1;
                    byte_we    = '1;
                    line_in    = pmem_rdata;
                    next_state = CHECK;
                end
            end
            default: next_state = CHECK;
        endcase
        // Reset abandons any transfer, so nothing may land in the arrays that cycle.
        if (rst) begin
            byte_we   = '0;
            fill      = 1'b0;
            set_dirty = 1'b0;
        end
    end

endmodule

// File: tb/tb_l1_data_cache.sv
// Directed bench for l1_data_cache: a set/line-address cache model plus a memory model,
// checked against the DUT every cycle, with hand-computed expectations per scenario.
module tb_l1_data_cache;
    import cache_types::*;

    localparam int M_IDLE = 0;
    localparam int M_WB   = 1;
    localparam int M_FILL = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  data_addr;
    logic [31:0]  data_wdata;
    logic [3:0]   data_mbe;
    logic         data_read;
    logic         data_write;
    logic [31:0]  data_rdata;
    logic         data_resp;
    logic [31:0]  pmem_address;
    line_t        pmem_rdata;
    line_t        pmem_wdata;
    logic         pmem_read;
    logic         pmem_write;
    logic         pmem_resp;
    cache_state_t fsm_state;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Model: per-set line address (instead of tag), contents, valid/dirty, plus backing memory.
    bit          m_valid [8];
    bit          m_dirty [8];
    logic [31:0] m_laddr [8];
    line_t       m_line  [8];
    int          m_phase;
    line_t       mem [int unsigned];

    // Per-request observations filled in by do_req.
    int          wb_cycles;
    int          fill_cycles;
    logic [31:0] wb_addr;
    logic [31:0] wb_word1;
    logic [31:0] fill_addr;

    l1_data_cache dut (
        .clk          (clk),
        .rst          (rst),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_mbe     (data_mbe),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_rdata   (data_rdata),
        .data_resp    (data_resp),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_wdata   (pmem_wdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_resp    (pmem_resp),
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // Default memory pattern: each word holds its own byte address XOR 0xA5A50000.
    function automatic line_t mem_get(input logic [31:0] la);
        line_t l;
        if (mem.exists(la)) return mem[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la | (i << 2)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    task automatic check(input string name, input line_t act, input line_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(data_read && data_write))
            else $error("data_read and data_write asserted together");
        end
    end

    // Model update on each active edge.
    always @(posedge clk) begin
        int          idx;
        logic [31:0] la;
        int          w;
        idx = data_addr[7:5];
        la  = {data_addr[31:5], 5'b0};
        w   = data_addr[4:2];
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 0;
                m_dirty[i] = 0;
            end
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE: begin
                    if (data_read || data_write) begin
                        if (m_valid[idx] && m_laddr[idx] == la) begin
                            if (data_write) begin
                                for (int b = 0; b < 4; b++)
                                    if (data_mbe[b]) m_line[idx][w*32 + b*8 +: 8] = data_wdata[b*8 +: 8];
                                if (data_mbe != 0) m_dirty[idx] = 1;
                            end
                        end else if (m_valid[idx] && m_dirty[idx]) begin
                            m_phase = M_WB;
                        end else begin
                            m_phase = M_FILL;
                        end
                    end
                end
                M_WB: begin
                    if (pmem_resp) begin
                        mem[m_laddr[idx]] = m_line[idx];
                        m_phase = M_FILL;
                    end
                end
                default: begin
                    if (pmem_resp) begin
                        m_line[idx]  = mem_get(la);
                        m_laddr[idx] = la;
                        m_valid[idx] = 1;
                        m_dirty[idx] = 0;
                        m_phase      = M_IDLE;
                    end
                end
            endcase
        end
    end

    // Compare process: outputs sampled mid-cycle against the model.
    always @(negedge clk) begin
        int          idx;
        logic [31:0] la;
        bit          req;
        bit          hit;
        if (chk_en) begin
            idx = data_addr[7:5];
            la  = {data_addr[31:5], 5'b0};
            req = data_read || data_write;
            check("pmem_excl", line_t'(pmem_read && pmem_write), line_t'(0));
            case (m_phase)
                M_IDLE: begin
                    hit = req && m_valid[idx] && m_laddr[idx] == la;
                    check("idle_resp", line_t'(data_resp), line_t'(hit));
                    check("idle_pread", line_t'(pmem_read), line_t'(0));
                    check("idle_pwrite", line_t'(pmem_write), line_t'(0));
                    if (hit && data_read && !data_write)
                        check("hit_rdata", line_t'(data_rdata), line_t'(m_line[idx][data_addr[4:2]*32 +: 32]));
                end
                M_WB: begin
                    check("wb_resp", line_t'(data_resp), line_t'(0));
                    check("wb_pwrite", line_t'(pmem_write), line_t'(1));
                    check("wb_addr", line_t'(pmem_address), line_t'(m_laddr[idx]));
                    check("wb_data", pmem_wdata, m_line[idx]);
                end
                default: begin
                    check("fill_resp", line_t'(data_resp), line_t'(0));
                    check("fill_pread", line_t'(pmem_read), line_t'(1));
                    check("fill_addr", line_t'(pmem_address), line_t'(la));
                end
            endcase
        end
    end

    // Drive one request (called #1 after a rising edge); the bench answers pmem after lat cycles.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input int lat,
                          output logic [31:0] rdata_out, output int cycles);
        bit got;
        int wait_cnt;
        got = 0; wait_cnt = 0; cycles = -1; rdata_out = 'x;
        wb_cycles = 0; fill_cycles = 0; wb_addr = 'x; wb_word1 = 'x; fill_addr = 'x;
        data_read = rd; data_write = wr; data_addr = a; data_wdata = wd; data_mbe = m;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (data_resp) begin
                got = 1; rdata_out = data_rdata; cycles = c;
            end else if (pmem_read || pmem_write) begin
                if (pmem_write) begin
                    wb_cycles++; wb_addr = pmem_address; wb_word1 = pmem_wdata[63:32];
                end else begin
                    fill_cycles++; fill_addr = pmem_address;
                end
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    pmem_rdata = mem_get(pmem_address);
                    pmem_resp  = 1'b1;
                    wait_cnt   = 0;
                end
            end
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (got) break;
        end
        data_read = 0; data_write = 0;
        if (!got) begin
            n_tests++; n_fail++;
            $display("FAIL req_timeout addr=%0h no data_resp within 200 cycles", a);
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          pm_total;
        bit          seen;
        line_t       l;

        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0; m_dirty[i] = 0; m_laddr[i] = '0; m_line[i] = '0;
        end
        m_phase = M_IDLE;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = (32'h1000 | (i << 2)) ^ 32'hA5A5_0000;
        l[63:32] = 32'hDEAD_BEEF;
        mem[32'h1000] = l;

        rst = 1; data_addr = 0; data_wdata = 0; data_mbe = 0; data_read = 0; data_write = 0;
        pmem_resp = 0; pmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1;
        rst = 0;
        @(negedge clk);
        check("reset_resp", line_t'(data_resp), line_t'(0));
        check("reset_pread", line_t'(pmem_read), line_t'(0));
        check("reset_pwrite", line_t'(pmem_write), line_t'(0));
        @(posedge clk); #1;

        // Cold read: 1 miss cycle + 3 fill cycles, hit on the 5th.
        do_req(1, 0, 32'h0000_1004, 0, 0, 3, rd, cyc);
        check("cold_rdata", line_t'(rd), line_t'(32'hDEAD_BEEF));
        check("cold_cycles", line_t'(cyc), line_t'(4));
        check("cold_fill_addr", line_t'(fill_addr), line_t'(32'h0000_1000));
        check("cold_no_wb", line_t'(wb_cycles), line_t'(0));

        // Partial store hit, then zero-wait read back.
        do_req(0, 1, 32'h0000_1004, 32'h1234_5678, 4'b0011, 3, rd, cyc);
        check("store_cycles", line_t'(cyc), line_t'(0));
        do_req(1, 0, 32'h0000_1004, 0, 0, 3, rd, cyc);
        check("store_rb_rdata", line_t'(rd), line_t'(32'hDEAD_5678));
        check("store_rb_cycles", line_t'(cyc), line_t'(0));

        // Dirty eviction: 1 miss + 2 writeback + 2 fill, hit on the 6th cycle.
        do_req(1, 0, 32'h0000_2004, 0, 0, 2, rd, cyc);
        check("evict_wb_addr", line_t'(wb_addr), line_t'(32'h0000_1000));
        check("evict_wb_word1", line_t'(wb_word1), line_t'(32'hDEAD_5678));
        check("evict_fill_addr", line_t'(fill_addr), line_t'(32'h0000_2000));
        check("evict_rdata", line_t'(rd), line_t'(32'hA5A5_2004));
        check("evict_cycles", line_t'(cyc), line_t'(5));
        check("evict_mem_word1", line_t'(mem[32'h1000][63:32]), line_t'(32'hDEAD_5678));

        // Clean miss: straight to fill.
        do_req(1, 0, 32'h0000_3004, 0, 0, 1, rd, cyc);
        check("clean_no_wb", line_t'(wb_cycles), line_t'(0));
        check("clean_fill_addr", line_t'(fill_addr), line_t'(32'h0000_3000));
        check("clean_rdata", line_t'(rd), line_t'(32'hA5A5_3004));
        check("clean_cycles", line_t'(cyc), line_t'(2));

        // Warm sets 1 and 2, then alternate hits every cycle.
        do_req(1, 0, 32'h0000_0024, 0, 0, 1, rd, cyc);
        do_req(1, 0, 32'h0000_0044, 0, 0, 1, rd, cyc);
        pm_total = 0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0)
                do_req(0, 1, (i % 4 == 0) ? 32'h0000_0024 : 32'h0000_0044, 32'h1111_1111 * (i + 1), 4'b1111, 1, rd, cyc);
            else
                do_req(1, 0, (i % 4 == 1) ? 32'h0000_0024 : 32'h0000_0044, 0, 0, 1, rd, cyc);
            check("b2b_cycles", line_t'(cyc), line_t'(0));
            pm_total += wb_cycles + fill_cycles;
        end
        check("b2b_no_pmem", line_t'(pm_total), line_t'(0));
        check("b2b_last_rdata", line_t'(rd), line_t'(32'h7777_7777));

        // Reset in the middle of a fill, then a stray pmem_resp.
        data_read = 1; data_addr = 32'h0000_0064; seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (pmem_read) begin seen = 1; break; end
        end
        check("midfill_seen", line_t'(seen), line_t'(1));
        rst = 1;
        @(posedge clk); #1;
        data_read = 0;
        @(negedge clk);
        check("midfill_pread_drop", line_t'(pmem_read), line_t'(0));
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        pmem_rdata = '1; pmem_resp = 1;
        @(posedge clk); #1;
        pmem_resp = 0;
        do_req(1, 0, 32'h0000_0064, 0, 0, 1, rd, cyc);
        check("midfill_remiss", line_t'(cyc), line_t'(2));
        check("midfill_rdata", line_t'(rd), line_t'(32'hA5A5_0064));
        do_req(1, 0, 32'h0000_3004, 0, 0, 1, rd, cyc);
        check("post_rst_cleared", line_t'(cyc), line_t'(2));

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
